// File: rtl/sample_packetizer.sv
// Frames FIFO samples into packets: a header word (magic + sequence), PKT_LEN
// payload samples passed straight through, and a trailing XOR checksum word.
module sample_packetizer #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          PKT_LEN       = 256,
  parameter logic [15:0] MAGIC         = 16'hA5C3,
  parameter int          STARVE_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_data_vld,
  output logic                  in_data_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_data_vld,
  input  logic                  out_data_rdy,
  output logic                  out_data_last,
  input  logic                  pkt_enable,
  output logic [15:0]           pkt_count,
  output logic                  event_starve
);
  localparam int WCW = $clog2(PKT_LEN + 1);
  localparam int SCW = $clog2(STARVE_CYCLES + 1);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(PKT_LEN - 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_CYCLES);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] checksum_q;
  logic [WCW-1:0]        word_cnt_q;
  logic [SCW-1:0]        wait_cnt_q;
  logic [15:0]           pkt_count_q, pkt_count_d;
  logic [DATA_WIDTH-1:0] header_word;
  logic                  pay_xfer, chk_xfer, starve_hit;

  assign header_word = DATA_WIDTH'({MAGIC, pkt_count_q});
  assign pay_xfer    = (state_q == PAYLOAD) && in_data_vld && out_data_rdy;
  assign chk_xfer    = (state_q == CHECKSUM) && out_data_rdy;
  assign pkt_count_d = chk_xfer ? pkt_count_q + 16'd1 : pkt_count_q;
  assign pkt_count   = pkt_count_q;
  // Fires on the wait cycle that brings the counter up to the threshold.
  assign starve_hit  = (state_q == PAYLOAD) && !in_data_vld &&
                       (wait_cnt_q == STARVE_MAX - 1'b1);

  always_comb begin
    state_d       = state_q;
    in_data_rdy   = 1'b0;
    out_data      = '0;
    out_data_vld  = 1'b0;
    out_data_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_enable && in_data_vld) state_d = HEADER;
      end
      HEADER: begin
        out_data     = header_word;
        out_data_vld = 1'b1;
        if (out_data_rdy) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        out_data     = in_data;
        out_data_vld = in_data_vld;
        in_data_rdy  = out_data_rdy;
        if (pay_xfer && (word_cnt_q == LAST_WORD)) state_d = CHECKSUM;
      end
      CHECKSUM: begin
        out_data      = checksum_q;
        out_data_vld  = 1'b1;
        out_data_last = 1'b1;
        if (out_data_rdy) state_d = (pkt_enable && in_data_vld) ? HEADER : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      checksum_q   <= '0;
      word_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      pkt_count_q  <= '0;
      event_starve <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_count_q  <= pkt_count_d;
      event_starve <= starve_hit;
      if ((state_q == IDLE) || chk_xfer) begin
        checksum_q <= '0;
        word_cnt_q <= '0;
      end else if (pay_xfer) begin
        checksum_q <= checksum_q ^ in_data;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
      if ((state_q != PAYLOAD) || pay_xfer) wait_cnt_q <= '0;
      else if (!in_data_vld && (wait_cnt_q != STARVE_MAX)) wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
endmodule
